// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the M-stage data-memory responder: access sizes,
// register-window layout and the byte-merge helper used by every store target.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_NONE = 2'b11
  } size_e;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'h8000_0000;

  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_TIMER  = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int unsigned STATUS_MISALIGN_BIT = 0;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = oldWord;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = newWord[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_store_lane_gen.sv
// Store lane generator: turns address low bits and access size into byte
// enables, replicated lane data and a misalignment flag.
module store_lane_gen
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  funct3,
  input  logic [31:0] writeData,
  output logic [3:0]  be,
  output logic [31:0] laneData,
  output logic        misaligned
);

  size_e sz;

  always_comb begin
    sz         = size_e'(funct3);
    be         = '0;
    laneData   = '0;
    misaligned = 1'b0;
    unique case (sz)
      SZ_B: begin
        be       = 4'b0001 << addrLo;
        laneData = {4{writeData[7:0]}};
      end
      SZ_H: begin
        be         = addrLo[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{writeData[15:0]}};
        misaligned = addrLo[0];
      end
      SZ_W: begin
        be         = '1;
        laneData   = writeData;
        misaligned = (addrLo != 2'b00);
      end
      default: begin
        be = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with combinational read plus GPIO, free-running
// timer and sticky misalignment status in a register window selected by addr[31].
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] MemDataM,
  output logic [31:0] GpioOut,
  output logic        MisalignM
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      ram [DEPTH_WORDS];
  logic [IDX_W-1:0] wordIdx;
  logic [3:0]       be;
  logic [31:0]      laneData;
  logic             misaligned;
  logic [31:0]      timerReg;
  logic             isMmio;
  logic             commit;
  logic             ramWr, gpioWr, timerWr, statusWr;
  logic             unusedBits;

  store_lane_gen uLane (
    .addrLo    (ALUResultM[1:0]),
    .funct3    (Funct3M[1:0]),
    .writeData (WriteDataM),
    .be        (be),
    .laneData  (laneData),
    .misaligned(misaligned)
  );

  always_comb begin
    wordIdx    = ALUResultM[IDX_W+1:2];
    isMmio     = (ALUResultM[31] == MMIO_BASE[31]);
    commit     = MemWriteM && !misaligned && (be != '0);
    ramWr      = commit && !isMmio;
    gpioWr     = commit && isMmio && (ALUResultM[3:2] == OFF_GPIO[3:2]);
    timerWr    = commit && isMmio && (ALUResultM[3:2] == OFF_TIMER[3:2]);
    statusWr   = commit && isMmio && (ALUResultM[3:2] == OFF_STATUS[3:2]);
    unusedBits = ^{ALUResultM[30:IDX_W+2], Funct3M[2]};
  end

  // RAM has no reset; a store in a reset cycle is dropped to match the registers.
  always_ff @(posedge clk) begin
    if (ramWr && !reset) ram[wordIdx] <= mergeBytes(ram[wordIdx], laneData, be);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      GpioOut <= '0;
    end else if (gpioWr) begin
      GpioOut <= mergeBytes(GpioOut, laneData, be);
    end
  end

  // A timer store replaces the increment; unwritten bytes keep the pre-increment value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timerReg <= '0;
    end else if (timerWr) begin
      timerReg <= mergeBytes(timerReg, laneData, be);
    end else begin
      timerReg <= timerReg + 32'd1;
    end
  end

  // Set on a dropped misaligned store wins over a write-one-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MisalignM <= 1'b0;
    end else if (MemWriteM && misaligned) begin
      MisalignM <= 1'b1;
    end else if (statusWr && be[STATUS_MISALIGN_BIT] && laneData[STATUS_MISALIGN_BIT]) begin
      MisalignM <= 1'b0;
    end
  end

  always_comb begin
    MemDataM = '0;
    if (isMmio) begin
      unique case (ALUResultM[3:2])
        OFF_GPIO[3:2]:   MemDataM = GpioOut;
        OFF_TIMER[3:2]:  MemDataM = timerReg;
        OFF_STATUS[3:2]: MemDataM[STATUS_MISALIGN_BIT] = MisalignM;
        default:         MemDataM = '0;
      endcase
    end else begin
      MemDataM = ram[wordIdx];
    end
  end

endmodule
